parity_frame_ctrl: RTL and testbench
====================================

// Module: parity_frame_ctrl
// PURPOSE
// - Sequences a serial bit stream into fixed-length frames: DATA_W data bits then 1 parity bit.
// - Drives an internal even/odd parity tracker, assembles the data word and checks the parity bit.
// - Presents {word, parity error} to a downstream consumer through a 1-entry valid/ready buffer.
// - Sits between the serial line sampler and the word-level consumer logic.
// PARAMETERS
// - DATA_W      8   data bits per frame, 2..32; bits arrive LSB first
// - ODD_PARITY  1   1: total ones over data+parity must be odd; 0: must be even
// PORTS
// - clk          input   1       rising-edge clock
// - reset        input   1       asynchronous, active-low reset
// - bit_in       input   1       serial data bit, sampled only when bit_valid=1
// - bit_valid    input   1       bit strobe, one bit per cycle max
// - sof          input   1       start of frame; qualifies bit_in as data bit 0 (ignored if bit_valid=0)
// - word_out     output  DATA_W  assembled data word
// - parity_err   output  1       parity check failed for word_out
// - word_valid   output  1       word_out/parity_err hold a frame
// - word_ready   input   1       consumer accepts frame when word_valid & word_ready
// - frame_abort  output  1       1-cycle pulse: frame in progress discarded by new sof
// - overrun      output  1       1-cycle pulse: completed frame dropped, output buffer full
// BEHAVIOUR
// - Reset (async assert, sync release): FSM=IDLE, tracker=EVEN, bit_cnt=0; all outputs 0.
// - FSM states IDLE, DATA, PARITY; the output buffer is a separate valid flag.
// - IDLE: bit_valid&sof -> load bit 0, tracker cleared then updated, bit_cnt=1, DATA
//   (DATA_W=1 -> PARITY). bit_valid without sof is ignored.
// - DATA: each bit_valid shifts bit_in into position bit_cnt and toggles the tracker on 1.
//   bit_cnt==DATA_W-1 on accept -> PARITY. No bit_valid -> hold state, no timeout.
// - PARITY: bit_valid -> frame done; err = (tracker^bit_in) != ODD_PARITY; next state IDLE.
// - Completion with buffer empty, or buffer emptied by a handshake in that same cycle:
//   word_out/parity_err load and word_valid=1 the next cycle (latency 1 from the parity bit).
// - Completion with buffer full and no handshake: frame dropped, overrun=1 for 1 cycle;
//   the buffer is unchanged.
// - Buffer: word_valid stays 1 with word_out/parity_err stable until word_valid&word_ready.
// - sof&bit_valid while in DATA or PARITY: frame_abort=1 for 1 cycle, partial frame discarded.
//   The same bit starts a new frame as in IDLE; the abort never touches the output buffer.
// - Tracker and word updates occur only on bit_valid; bit_in is don't-care otherwise.
// - Reset mid-frame or with the buffer full: everything cleared, pending frame lost, no pulses.
// CONFIGURATION
// - Macro PARITY_ERR_CNT_EN:
//   - defined: extra output err_count[15:0] counts frames delivered to the buffer with
//     parity_err=1. It saturates at 16'hFFFF, is cleared only by reset, and excludes
//     dropped and aborted frames.
//   - undefined: port and counter are absent; behaviour is otherwise identical.
// STRUCTURE
// - Package parity_pkg:
//   - typedef enum logic {EVEN, ODD} parity_t
//   - typedef enum logic [1:0] {IDLE, DATA, PARITY} frame_state_t
//   - localparam ERR_CNT_W = 16
// - Sub-module parity_tracker:
//   - ports clk, reset, clear, en, bit_in, parity (parity_t)
//   - clear has priority over en; clear&en leaves parity = bit_in ? ODD : EVEN
//   - one instance here
// TESTING (DATA_W=8, ODD_PARITY=1, word_ready=1 unless stated)
// - sof+bits 1,0,1,0,0,0,0,0 (0x05), parity 1 -> next cycle word_out=0x05, parity_err=0, word_valid=1.
// - Same data, parity bit 0 -> word_out=0x05, parity_err=1; err_count 0->1 when PARITY_ERR_CNT_EN.
// - word_ready=0, two complete frames -> first held stable, overrun pulse on second parity bit;
//   word_ready=1 -> first frame accepted, word_valid=0.
// - 4 data bits then sof with 8 bits 0xFF, parity 1 -> frame_abort 1 cycle,
//   word_out=0xFF, parity_err=0.
// - Gaps (bit_valid=0 for 5 cycles) between bits of frame 0xA3 -> same result as gap-free.
// - reset low during DATA and with word_valid=1 -> all outputs 0 immediately;
//   next sof frame decodes correctly.

Source files
------------

// File: rtl/parity_pkg.sv
// parity_pkg: shared types and widths for the parity frame controller.
package parity_pkg;
  typedef enum logic {EVEN, ODD} parity_t;
  typedef enum logic [1:0] {IDLE, DATA, PARITY} frame_state_t;
  localparam int ERR_CNT_W = 16;
endpackage

// File: rtl/parity_tracker.sv
// parity_tracker: running even/odd parity over accepted bits; clear wins over en.
module parity_tracker
  import parity_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clear,
  input  logic    en,
  input  logic    bit_in,
  output parity_t parity
);
  parity_t parity_q, parity_d;
  always_comb
    parity_d = clear ? ((en && bit_in) ? ODD : EVEN)
             : (en && bit_in) ? ((parity_q == ODD) ? EVEN : ODD) : parity_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) parity_q <= EVEN;
    else parity_q <= parity_d;
  assign parity = parity_q;
endmodule

// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: frames a serial stream into DATA_W bits + parity and buffers {word, parity_err}.
// Define PARITY_ERR_CNT_EN to add the saturating err_count output.
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] word_out,
  output logic              parity_err,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_abort,
  output logic              overrun
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  frame_state_t state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, word_q, word_d;
  logic perr_q, perr_d, wv_q, wv_d, abort_q, abort_d, ovr_q, ovr_d;
  logic start, done, load, err;
  parity_t parity;
  assign start = bit_valid && sof;
  assign done  = bit_valid && !sof && state_q == PARITY;
  assign load  = done && (!wv_q || word_ready);
  assign err   = (logic'(parity) ^ bit_in) != ODD_PARITY;
  parity_tracker u_tracker (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .en    (bit_valid && (sof || state_q == DATA)),
    .bit_in(bit_in),
    .parity(parity)
  );
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (start) begin
      state_d   = (DATA_W == 1) ? PARITY : DATA;
      bit_cnt_d = CNT_W'(1);
      shift_d   = DATA_W'(bit_in);
    end else if (bit_valid && state_q == DATA) begin
      shift_d[bit_cnt_q] = bit_in;
      bit_cnt_d = bit_cnt_q + 1'b1;
      state_d   = (bit_cnt_q == LAST) ? PARITY : DATA;
    end else if (done) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end
    word_d  = load ? shift_q : word_q;
    perr_d  = load ? err : perr_q;
    wv_d    = load || (wv_q && !word_ready);
    abort_d = start && state_q != IDLE;
    ovr_d   = done && wv_q && !word_ready;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      perr_q    <= 1'b0;
      wv_q      <= 1'b0;
      abort_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      perr_q    <= perr_d;
      wv_q      <= wv_d;
      abort_q   <= abort_d;
      ovr_q     <= ovr_d;
    end
  assign word_out    = word_q;
  assign parity_err  = perr_q;
  assign word_valid  = wv_q;
  assign frame_abort = abort_q;
  assign overrun     = ovr_q;
`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (load && err && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign err_count = cnt_q;
`endif
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb_parity_frame_ctrl: directed checks of framing, parity, buffering, abort, overrun and reset.
module tb_parity_frame_ctrl;
  import parity_pkg::*;
  logic clk = 1'b0, reset = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, sof = 1'b0, word_ready = 1'b1;
  logic [7:0] word_out;
  logic parity_err, word_valid, frame_abort, overrun;
  int tests = 0, fails = 0;
`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count;
`endif
  parity_frame_ctrl #(.DATA_W(8), .ODD_PARITY(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .sof        (sof),
    .word_out   (word_out),
    .parity_err (parity_err),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_abort(frame_abort),
    .overrun    (overrun)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic b, input logic s);
    bit_in = b;
    sof = s;
    bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
    sof = 1'b0;
  endtask
  task automatic frame(input logic [7:0] w, input logic p, input int gap);
    for (int i = 0; i < 8; i++) begin
      send(w[i], i == 0);
      for (int g = 0; g < gap; g++) step();
    end
    send(p, 1'b0);
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word_out, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_abort", frame_abort, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;
    step();
    frame(8'h05, 1'b1, 0);
    chk("ok_valid", word_valid, 1);
    chk("ok_word", word_out, 8'h05);
    chk("ok_perr", parity_err, 0);
    step();
    chk("ok_accepted", word_valid, 0);
    frame(8'h05, 1'b0, 0);
    chk("bad_word", word_out, 8'h05);
    chk("bad_perr", parity_err, 1);
`ifdef PARITY_ERR_CNT_EN
    chk("bad_cnt", err_count, 1);
`endif
    step();
    frame(8'h07, 1'b0, 0);
    chk("odd3_perr", parity_err, 0);
    chk("odd3_word", word_out, 8'h07);
    step();
    word_ready = 1'b0;
    frame(8'h11, 1'b1, 0);
    chk("hold1_valid", word_valid, 1);
    chk("hold1_word", word_out, 8'h11);
    chk("hold1_noovr", overrun, 0);
    frame(8'h22, 1'b1, 0);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_word_stable", word_out, 8'h11);
    chk("ovr_valid", word_valid, 1);
    step();
    chk("ovr_one_cycle", overrun, 0);
    chk("hold2_word", word_out, 8'h11);
    word_ready = 1'b1;
    step();
    chk("drain_valid", word_valid, 0);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    chk("abort_pulse", frame_abort, 1);
    chk("abort_buf", word_valid, 0);
    for (int i = 0; i < 7; i++) send(1'b1, 1'b0);
    chk("abort_one_cycle", frame_abort, 0);
    send(1'b1, 1'b0);
    chk("abort_valid", word_valid, 1);
    chk("abort_word", word_out, 8'hFF);
    chk("abort_perr", parity_err, 0);
    step();
    frame(8'hA3, 1'b1, 5);
    chk("gap_valid", word_valid, 1);
    chk("gap_word", word_out, 8'hA3);
    chk("gap_perr", parity_err, 0);
    step();
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rstdata_valid", word_valid, 0);
    chk("rstdata_word", word_out, 0);
    step();
    reset = 1'b1;
    step();
    word_ready = 1'b0;
    frame(8'h05, 1'b0, 0);
    chk("pre_rst_valid", word_valid, 1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rstfull_valid", word_valid, 0);
    chk("rstfull_word", word_out, 0);
    chk("rstfull_perr", parity_err, 0);
    chk("rstfull_abort", frame_abort, 0);
    chk("rstfull_ovr", overrun, 0);
`ifdef PARITY_ERR_CNT_EN
    chk("rstfull_cnt", err_count, 0);
`endif
    step();
    reset = 1'b1;
    word_ready = 1'b1;
    step();
    frame(8'h3C, 1'b1, 0);
    chk("post_valid", word_valid, 1);
    chk("post_word", word_out, 8'h3C);
    chk("post_perr", parity_err, 0);
    chk("post_abort", frame_abort, 0);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
